// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared state type and default widths for the ring-oscillator measurement blocks
// Contents: clk_gen_fm_state_e (meter FSM states), CLK_GEN_CNT_W / CLK_GEN_WIN_W default widths
package clk_gen_pkg;
    localparam int CLK_GEN_CNT_W = 16;
    localparam int CLK_GEN_WIN_W = 16;
    typedef enum logic [1:0] {IDLE, MEASURE, DONE} clk_gen_fm_state_e;
endpackage

// File: rtl/clk_gen_sync_edge.sv
// clk_gen_sync_edge: 2-flop synchroniser plus previous flop, single-cycle rising-edge pulse
// Ports: clk_i system clock, reset_i sync active-high reset, d_i asynchronous input,
//        rise_o one-cycle pulse when the synchronised input goes 0->1
module clk_gen_sync_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic rise_o
);
    logic r_s1;
    logic r_s2;
    logic r_prev;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= d_i;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end
    assign rise_o = r_s2 & ~r_prev;
endmodule

// File: rtl/clk_gen_freq_meter.sv
// clk_gen_freq_meter: counts ring-oscillator rising edges over a window of clk_i cycles
// Ports: clk_i/reset_i clock and sync active-high reset; osc_i async oscillator output;
//        window_i/start_i measurement request; busy_o, v_o, count_o, sat_o result; yumi_i result accept
module clk_gen_freq_meter
    import clk_gen_pkg::*;
#(
    parameter int CNT_W = CLK_GEN_CNT_W,
    parameter int WIN_W = CLK_GEN_WIN_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             osc_i,
    input  logic [WIN_W-1:0] window_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             v_o,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o,
    input  logic             yumi_i
);
    clk_gen_fm_state_e r_state;
    clk_gen_fm_state_e w_next;
    logic [WIN_W-1:0]  r_win;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sat;
    logic              w_rise;
    clk_gen_sync_edge u_sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d_i    (osc_i),
        .rise_o (w_rise)
    );
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && start_i)
            w_next = (window_i == '0) ? DONE : MEASURE;
        else if (r_state == MEASURE && r_win == WIN_W'(1))
            w_next = DONE;
        else if (r_state == DONE && yumi_i)
            w_next = IDLE;
    end
    // sat marks an edge lost to saturation; a count that lands exactly on all-ones is still exact
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_win   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start_i) begin
                r_win <= window_i;
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (r_state == MEASURE) begin
                r_win <= r_win - WIN_W'(1);
                if (w_rise) begin
                    if (&r_cnt) r_sat <= 1'b1;
                    else r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end
    assign busy_o  = (r_state != IDLE);
    assign v_o     = (r_state == DONE);
    assign count_o = r_cnt;
    assign sat_o   = r_sat;
endmodule
